// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus arbiter.
// Entry layout, source ids and round-robin helper.
package cdb_pkg;

    localparam int N_SRC      = 3;
    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSQ = 2'd1,
        SRC_MUL = 2'd2
    } src_e;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  changeFlow;
        logic [CDB_DATA_W-1:0] jb_addr;
    } cdb_entry_t;

    // Successor of a source id, modulo N_SRC.
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO feeding the CDB arbiter.
// Flush empties it; push and pop may coincide.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = cdb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t entry_in,
    input  logic   pop,
    input  logic   flush,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == CW'(DEPTH));
    assign head   = r_mem[r_rd];
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= entry_in;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter from ALU/LSQ/MUL result FIFOs
// onto a single registered common data bus.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_changeFlow,
    input  logic [DATA_W-1:0] alu_jb_addr,
    input  logic              lsq_valid,
    output logic              lsq_ready,
    input  logic [TAG_W-1:0]  lsq_tag,
    input  logic [DATA_W-1:0] lsq_data,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_changeFlow,
    output logic [DATA_W-1:0] cdb_jb_addr,
    output logic [1:0]        cdb_src
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              changeFlow;
        logic [DATA_W-1:0] jb_addr;
    } entry_t;

    entry_t w_alu_in, w_lsq_in, w_mul_in;
    entry_t w_alu_hd, w_lsq_hd, w_mul_hd;
    entry_t w_sel;

    logic [N_SRC-1:0] w_empty;
    logic [N_SRC-1:0] w_full;
    logic [N_SRC-1:0] w_pop;
    logic             w_gnt;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_idx;
    logic [1:0]       r_rr;

    assign w_alu_in = '{tag: alu_tag, data: alu_data,
                        changeFlow: alu_changeFlow,
                        jb_addr: alu_jb_addr};
    assign w_lsq_in = '{tag: lsq_tag, data: lsq_data,
                        changeFlow: 1'b0, jb_addr: '0};
    assign w_mul_in = '{tag: mul_tag, data: mul_data,
                        changeFlow: 1'b0, jb_addr: '0};

    // Ready depends only on stored occupancy.
    assign alu_ready = ~w_full[SRC_ALU];
    assign lsq_ready = ~w_full[SRC_LSQ];
    assign mul_ready = ~w_full[SRC_MUL];

    cdb_src_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_alu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (alu_valid),
        .entry_in (w_alu_in),
        .pop      (w_pop[SRC_ALU]),
        .flush    (flush),
        .head     (w_alu_hd),
        .empty    (w_empty[SRC_ALU]),
        .full     (w_full[SRC_ALU])
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_lsq_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (lsq_valid),
        .entry_in (w_lsq_in),
        .pop      (w_pop[SRC_LSQ]),
        .flush    (flush),
        .head     (w_lsq_hd),
        .empty    (w_empty[SRC_LSQ]),
        .full     (w_full[SRC_LSQ])
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mul_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (mul_valid),
        .entry_in (w_mul_in),
        .pop      (w_pop[SRC_MUL]),
        .flush    (flush),
        .head     (w_mul_hd),
        .empty    (w_empty[SRC_MUL]),
        .full     (w_full[SRC_MUL])
    );

    // First non-empty head starting at rr_ptr; flush suppresses grants.
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = r_rr;
        w_idx     = r_rr;
        for (int k = 0; k < N_SRC; k++) begin
            if (!w_gnt && !w_empty[w_idx]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = w_idx;
            end
            w_idx = rr_next(w_idx);
        end
        if (flush) w_gnt = 1'b0;
    end

    // One-hot pop of the granted FIFO.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pop[i] = w_gnt && (w_gnt_idx == 2'(i));
        end
    end

    // Head mux for the granted source.
    always_comb begin
        w_sel = w_alu_hd;
        unique case (1'b1)
            w_pop[SRC_LSQ]: w_sel = w_lsq_hd;
            w_pop[SRC_MUL]: w_sel = w_mul_hd;
            default:        w_sel = w_alu_hd;
        endcase
    end

    // CDB registers and round-robin pointer; payload holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr           <= 2'd0;
            cdb_valid      <= 1'b0;
            cdb_tag        <= '0;
            cdb_data       <= '0;
            cdb_changeFlow <= 1'b0;
            cdb_jb_addr    <= '0;
            cdb_src        <= 2'd0;
        end else begin
            cdb_valid <= w_gnt;
            if (w_gnt) begin
                r_rr           <= rr_next(w_gnt_idx);
                cdb_tag        <= w_sel.tag;
                cdb_data       <= w_sel.data;
                cdb_changeFlow <= w_sel.changeFlow;
                cdb_jb_addr    <= w_sel.jb_addr;
                cdb_src        <= w_gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter against a queue-based model.
// Directed scenarios first, then random traffic with flushes.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int DEPTH = 2;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          cf;
        logic [DW-1:0] jb;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          v   [3];
    logic          rdy [3];
    logic [TW-1:0] tg  [3];
    logic [DW-1:0] dt  [3];
    logic          cf;
    logic [DW-1:0] jb;

    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          cdb_changeFlow;
    logic [DW-1:0] cdb_jb_addr;
    logic [1:0]    cdb_src;

    ent_t          q [3][$];
    bit            last_acc [3];
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic          m_cf;
    logic [DW-1:0] m_jb;
    int            m_src;
    int            m_rr;

    int n_checks;
    int n_errors;
    int n_disc_seen;

    cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .alu_valid      (v[0]),
        .alu_ready      (rdy[0]),
        .alu_tag        (tg[0]),
        .alu_data       (dt[0]),
        .alu_changeFlow (cf),
        .alu_jb_addr    (jb),
        .lsq_valid      (v[1]),
        .lsq_ready      (rdy[1]),
        .lsq_tag        (tg[1]),
        .lsq_data       (dt[1]),
        .mul_valid      (v[2]),
        .mul_ready      (rdy[2]),
        .mul_tag        (tg[2]),
        .mul_data       (dt[2]),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_changeFlow (cdb_changeFlow),
        .cdb_jb_addr    (cdb_jb_addr),
        .cdb_src        (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            last_acc[i] = 0;
        end
        m_valid = 0;
        m_tag   = '0;
        m_data  = '0;
        m_cf    = 0;
        m_jb    = '0;
        m_src   = 0;
        m_rr    = 0;
    endtask

    // Behaviour at one rising edge, from pre-edge model state.
    task automatic model_edge();
        bit   acc [3];
        int   g;
        ent_t e;
        for (int i = 0; i < 3; i++)
            acc[i] = v[i] && (q[i].size() < DEPTH) && !flush;
        if (flush) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            m_valid = 0;
        end else begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && q[(m_rr + k) % 3].size() > 0)
                    g = (m_rr + k) % 3;
            end
            if (g >= 0) begin
                e       = q[g].pop_front();
                m_valid = 1;
                m_tag   = e.tag;
                m_data  = e.data;
                m_cf    = e.cf;
                m_jb    = e.jb;
                m_src   = g;
                m_rr    = (g + 1) % 3;
            end else begin
                m_valid = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    e.tag  = tg[i];
                    e.data = dt[i];
                    e.cf   = (i == 0) ? cf : 1'b0;
                    e.jb   = (i == 0) ? jb : '0;
                    q[i].push_back(e);
                end
            end
        end
        for (int i = 0; i < 3; i++) last_acc[i] = acc[i];
    endtask

    task automatic check_all();
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        chk("cdb_data", 64'(cdb_data), 64'(m_data));
        chk("cdb_changeFlow", 64'(cdb_changeFlow), 64'(m_cf));
        chk("cdb_jb_addr", 64'(cdb_jb_addr), 64'(m_jb));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
        chk("alu_ready", 64'(rdy[0]), 64'(q[0].size() < DEPTH));
        chk("lsq_ready", 64'(rdy[1]), 64'(q[1].size() < DEPTH));
        chk("mul_ready", 64'(rdy[2]), 64'(q[2].size() < DEPTH));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (cdb_valid && cdb_tag >= 6'd60) n_disc_seen++;
    endtask

    task automatic idle_inputs();
        flush = 0;
        for (int i = 0; i < 3; i++) v[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Producers hold an offered entry until accepted.
    task automatic rand_drive(input int pct, input bit allow_flush);
        for (int i = 0; i < 3; i++) begin
            if (!v[i] || last_acc[i]) begin
                v[i]  = ($urandom_range(0, 99) < pct);
                tg[i] = TW'($urandom_range(0, 59));
                dt[i] = $urandom;
                if (i == 0) begin
                    cf = 1'($urandom_range(0, 1));
                    jb = $urandom;
                end
            end
        end
        flush = allow_flush && ($urandom_range(0, 29) == 0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        n_disc_seen = 0;
        rst_n       = 0;
        cf          = 0;
        jb          = '0;
        for (int i = 0; i < 3; i++) begin
            tg[i] = '0;
            dt[i] = '0;
        end
        idle_inputs();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;
        repeat (5) step();

        // Single ALU result, 1-cycle latency then idle.
        v[0] = 1; tg[0] = 6'd5; dt[0] = 32'h1234;
        cf = 1; jb = 32'h40;
        step();
        v[0] = 0;
        step();
        chk("t2_valid", 64'(cdb_valid), 64'd1);
        chk("t2_tag", 64'(cdb_tag), 64'd5);
        chk("t2_data", 64'(cdb_data), 64'h1234);
        chk("t2_cf", 64'(cdb_changeFlow), 64'd1);
        chk("t2_jb", 64'(cdb_jb_addr), 64'h40);
        chk("t2_src", 64'(cdb_src), 64'(SRC_ALU));
        step();
        chk("t2_idle", 64'(cdb_valid), 64'd0);

        // All three at once from rr_ptr 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1; tg[i] = TW'(10 + i); dt[i] = 32'(100 + i);
        end
        cf = 0; jb = '0;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_src", 64'(cdb_src), 64'(i));
            chk("t3_tag", 64'(cdb_tag), 64'(10 + i));
        end
        step();
        chk("t3_idle", 64'(cdb_valid), 64'd0);

        // LSQ backpressure while ALU takes the first grant.
        do_reset();
        v[0] = 1; tg[0] = 6'd20; dt[0] = 32'hA0;
        v[1] = 1; tg[1] = 6'd21; dt[1] = 32'hB0;
        step();
        tg[0] = 6'd22; tg[1] = 6'd23;
        step();
        chk("t4_lsq_full", 64'(rdy[1]), 64'd0);
        v[0] = 0; tg[1] = 6'd24;
        step();
        chk("t4_src", 64'(cdb_src), 64'(SRC_LSQ));
        chk("t4_tag", 64'(cdb_tag), 64'd21);
        chk("t4_lsq_free", 64'(rdy[1]), 64'd1);
        step();
        v[1] = 0;
        repeat (5) step();

        // Fill every FIFO, then flush with pushes pending.
        for (int i = 0; i < 3; i++) v[i] = 1;
        repeat (8) begin
            rand_drive(100, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            v[i] = 1; tg[i] = TW'(60 + i);
        end
        flush = 1;
        step();
        chk("t5_valid", 64'(cdb_valid), 64'd0);
        chk("t5_alu_rdy", 64'(rdy[0]), 64'd1);
        chk("t5_lsq_rdy", 64'(rdy[1]), 64'd1);
        chk("t5_mul_rdy", 64'(rdy[2]), 64'd1);
        idle_inputs();
        repeat (5) step();

        // Random traffic with occasional flushes.
        repeat (400) begin
            rand_drive(60, 1);
            step();
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 0;
        idle_inputs();
        #1;
        model_reset();
        check_all();
        chk("t6_async_valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        rst_n = 1;
        v[0] = 1; tg[0] = 6'd33; dt[0] = 32'hBEEF;
        cf = 0; jb = '0;
        step();
        v[0] = 0;
        step();
        chk("t6_valid", 64'(cdb_valid), 64'd1);
        chk("t6_tag", 64'(cdb_tag), 64'd33);

        repeat (200) begin
            rand_drive(80, 1);
            step();
        end
        idle_inputs();
        repeat (4) step();

        chk("discarded_tag_seen", 64'(n_disc_seen), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
